// File: rtl/tdc_phase_decoder.sv
// Ring-oscillator TDC back end: thermometer phase decode with bubble flag, coarse/fine merge,
// wrap-safe per-cycle increment and a block averager feeding the loop filter.
module tdc_phase_decoder #(
    parameter int N_PHASES = 16,
    parameter int CNT_W    = 7,
    parameter int AVG_LOG2 = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    en,
    input  logic [N_PHASES-1:0]                     phase,
    input  logic [CNT_W-1:0]                        ripple_count,
    output logic [CNT_W+$clog2(2*N_PHASES)-1:0]     tdc_word,
    output logic                                    tdc_valid,
    output logic                                    bubble_err,
    output logic [CNT_W+$clog2(2*N_PHASES)-1:0]     delta,
    output logic                                    delta_valid,
    output logic [CNT_W+$clog2(2*N_PHASES)-1:0]     avg_delta,
    output logic                                    avg_valid
);

    localparam int FW = $clog2(2 * N_PHASES);
    localparam int TW = CNT_W + FW;
    localparam int AW = TW + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] WIN_LAST = CW'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [N_PHASES-2:0] T_ONE = (N_PHASES-1)'(1'b1);

    function automatic logic [FW-1:0] popcount(input logic [N_PHASES-1:0] w);
        logic [FW-1:0] c;
        c = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            c = c + FW'(w[i]);
        end
        return c;
    endfunction

    // Ones filling from bit 0 count up to N; zeros then fill from bit 0 to reach 2N-1.
    function automatic logic [FW-1:0] fine_decode(input logic [N_PHASES-1:0] w);
        logic [FW-1:0] f;
        if (w[0] || (w == '0)) begin
            f = popcount(w);
        end else begin
            f = FW'(N_PHASES) + popcount(~w);
        end
        return f;
    endfunction

    // A clean thermometer has at most one adjacent-bit transition; clearing the lowest
    // set bit of the transition vector leaves something only if there were two or more.
    function automatic logic is_bubble(input logic [N_PHASES-1:0] w);
        logic [N_PHASES-2:0] t;
        t = w[N_PHASES-2:0] ^ w[N_PHASES-1:1];
        return ((t & (t - T_ONE)) != '0);
    endfunction

    logic [N_PHASES-1:0] phase_q,     phase_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic                s1_valid_q,  s1_valid_d;
    logic [TW-1:0]       word_q,      word_d;
    logic                tdc_valid_q, tdc_valid_d;
    logic                bubble_q,    bubble_d;
    logic [TW-1:0]       prev_q,      prev_d;
    logic                have_prev_q, have_prev_d;
    logic [TW-1:0]       delta_q,     delta_d;
    logic                dvalid_q,    dvalid_d;
    logic                dlive_q,     dlive_d;
    logic [AW-1:0]       acc_q,       acc_d;
    logic [CW-1:0]       cnt_q,       cnt_d;
    logic [TW-1:0]       avg_q,       avg_d;
    logic                avalid_q,    avalid_d;

    logic [FW-1:0]       fine_s;
    logic                bubble_s;
    logic [AW-1:0]       sum_s;

    assign fine_s   = fine_decode(phase_q);
    assign bubble_s = is_bubble(phase_q);
    assign sum_s    = acc_q + AW'(delta_q);

    // Sample, decode/merge and difference stages.
    always_comb begin
        phase_d     = phase_q;
        count_d     = count_q;
        s1_valid_d  = 1'b0;
        word_d      = word_q;
        bubble_d    = bubble_q;
        tdc_valid_d = s1_valid_q;
        delta_d     = delta_q;
        prev_d      = prev_q;
        if (en) begin
            phase_d    = phase;
            count_d    = ripple_count;
            s1_valid_d = 1'b1;
        end else begin
            s1_valid_d = 1'b0;
        end
        if (s1_valid_q) begin
            word_d   = {count_q, fine_s};
            bubble_d = bubble_s;
        end else begin
            word_d   = word_q;
            bubble_d = bubble_q;
        end
        dvalid_d = tdc_valid_q & have_prev_q;
        // Deltas formed while en is low still drain out but are kept out of the next window.
        dlive_d  = tdc_valid_q & have_prev_q & en;
        if (dvalid_d) begin
            delta_d = word_q - prev_q;
        end else begin
            delta_d = delta_q;
        end
        if (tdc_valid_q) begin
            prev_d = word_q;
        end else begin
            prev_d = prev_q;
        end
        // Any gap in tdc_valid means the sample chain was broken by a flush.
        have_prev_d = en & tdc_valid_q;
    end

    // Block averager: accumulate live deltas, emit and restart on the last one of a window.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        avg_d    = avg_q;
        avalid_d = 1'b0;
        if (dlive_q) begin
            if (cnt_q == WIN_LAST) begin
                avg_d    = sum_s[AW-1 -: TW];
                avalid_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum_s;
                cnt_d = cnt_q + CW'(1'b1);
            end
        end else begin
            acc_d = acc_q;
        end
        if (!en) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            word_q      <= '0;
            tdc_valid_q <= 1'b0;
            bubble_q    <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            delta_q     <= '0;
            dvalid_q    <= 1'b0;
            dlive_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avalid_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            word_q      <= word_d;
            tdc_valid_q <= tdc_valid_d;
            bubble_q    <= bubble_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            delta_q     <= delta_d;
            dvalid_q    <= dvalid_d;
            dlive_q     <= dlive_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            avalid_q    <= avalid_d;
        end
    end

    assign tdc_word    = word_q;
    assign tdc_valid   = tdc_valid_q;
    assign bubble_err  = bubble_q;
    assign delta       = delta_q;
    assign delta_valid = dvalid_q;
    assign avg_delta   = avg_q;
    assign avg_valid   = avalid_q;

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Directed bench for tdc_phase_decoder at N_PHASES=16, CNT_W=7, AVG_LOG2=3 (12-bit TDC word).
module tb_tdc_phase_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] phase;
    logic [6:0]  ripple_count;
    logic [11:0] tdc_word;
    logic        tdc_valid;
    logic        bubble_err;
    logic [11:0] delta;
    logic        delta_valid;
    logic [11:0] avg_delta;
    logic        avg_valid;

    int n_checks = 0;
    int n_errors = 0;

    tdc_phase_decoder #(.N_PHASES(16), .CNT_W(7), .AVG_LOG2(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .phase(phase), .ripple_count(ripple_count),
        .tdc_word(tdc_word), .tdc_valid(tdc_valid), .bubble_err(bubble_err),
        .delta(delta), .delta_valid(delta_valid), .avg_delta(avg_delta), .avg_valid(avg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Thermometer pattern that carries a given fine code (0..31).
    function automatic logic [15:0] enc_phase(input int f);
        logic [15:0] ones;
        ones = 16'hFFFF;
        if (f <= 16) return ones >> (16 - f);
        else return ones << (f - 16);
    endfunction

    // Alternating +40/+56 word sequence: 0, 40, 96, 136, 192, 232, 288, ...
    function automatic int alt_word(input int s);
        return (s / 2) * 96 + (s % 2) * 40;
    endfunction

    task automatic step(input logic e, input logic [15:0] p, input logic [6:0] c);
        en = e; phase = p; ripple_count = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_w(input logic e, input int w);
        step(e, enc_phase(w % 32), 7'(w / 32));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0000, 7'd0);
    endtask

    task automatic test_reset;
        rst_n = 1'b1; en = 1'b0; phase = 16'h0000; ripple_count = 7'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tdc_word !== 12'd0) begin n_errors++; $display("FAIL reset_tdc_word: got %0d expected 0", tdc_word); end
        n_checks++; if (tdc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tdc_valid: got %0d expected 0", tdc_valid); end
        n_checks++; if (bubble_err !== 1'b0) begin n_errors++; $display("FAIL reset_bubble: got %0d expected 0", bubble_err); end
        n_checks++; if (delta !== 12'd0) begin n_errors++; $display("FAIL reset_delta: got %0d expected 0", delta); end
        n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL reset_delta_valid: got %0d expected 0", delta_valid); end
        n_checks++; if (avg_delta !== 12'd0) begin n_errors++; $display("FAIL reset_avg_delta: got %0d expected 0", avg_delta); end
        n_checks++; if (avg_valid !== 1'b0) begin n_errors++; $display("FAIL reset_avg_valid: got %0d expected 0", avg_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_decode;
        idle(3);
        step(1'b1, 16'h0007, 7'd5);
        n_checks++; if (tdc_valid !== 1'b0) begin n_errors++; $display("FAIL decode_latency: got valid %0d expected 0", tdc_valid); end
        step(1'b1, 16'hFFF8, 7'd6);
        n_checks++; if (tdc_word !== 12'd163) begin n_errors++; $display("FAIL decode_word0: got %0d expected 163", tdc_word); end
        n_checks++; if (tdc_valid !== 1'b1) begin n_errors++; $display("FAIL decode_valid0: got %0d expected 1", tdc_valid); end
        n_checks++; if (bubble_err !== 1'b0) begin n_errors++; $display("FAIL decode_bubble0: got %0d expected 0", bubble_err); end
        n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL decode_first_no_delta: got %0d expected 0", delta_valid); end
        step(1'b1, 16'hFFF8, 7'd6);
        n_checks++; if (tdc_word !== 12'd211) begin n_errors++; $display("FAIL decode_word1: got %0d expected 211", tdc_word); end
        n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL decode_delta_early: got %0d expected 0", delta_valid); end
        step(1'b0, 16'h0000, 7'd0);
        n_checks++; if (delta !== 12'd48) begin n_errors++; $display("FAIL decode_delta: got %0d expected 48", delta); end
        n_checks++; if (delta_valid !== 1'b1) begin n_errors++; $display("FAIL decode_delta_valid: got %0d expected 1", delta_valid); end
    endtask

    task automatic test_wrap;
        idle(3);
        step(1'b1, 16'h8000, 7'd127);
        step(1'b1, 16'h8000, 7'd0);
        n_checks++; if (tdc_word !== 12'd4095) begin n_errors++; $display("FAIL wrap_word_max: got %0d expected 4095", tdc_word); end
        step(1'b1, 16'h8000, 7'd0);
        n_checks++; if (tdc_word !== 12'd31) begin n_errors++; $display("FAIL wrap_word_low: got %0d expected 31", tdc_word); end
        step(1'b0, 16'h0000, 7'd0);
        n_checks++; if (delta !== 12'd32 || delta_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_delta: got %0d valid %0d expected 32 valid 1", delta, delta_valid); end
    endtask

    task automatic test_bubble;
        idle(3);
        step(1'b1, 16'h0005, 7'd3);
        step(1'b1, 16'h0000, 7'd3);
        n_checks++; if (tdc_word !== 12'd98) begin n_errors++; $display("FAIL bubble_word: got %0d expected 98", tdc_word); end
        n_checks++; if (bubble_err !== 1'b1) begin n_errors++; $display("FAIL bubble_flag: got %0d expected 1", bubble_err); end
        step(1'b0, 16'h0000, 7'd0);
        n_checks++; if (tdc_word !== 12'd96) begin n_errors++; $display("FAIL bubble_clean_word: got %0d expected 96", tdc_word); end
        n_checks++; if (bubble_err !== 1'b0) begin n_errors++; $display("FAIL bubble_clear: got %0d expected 0", bubble_err); end
    endtask

    task automatic test_averaging;
        int pulses;
        pulses = 0;
        idle(3);
        for (int s = 0; s < 24; s++) begin
            if (s <= 18) step_w(1'b1, alt_word(s));
            else step(1'b0, 16'h0000, 7'd0);
            if (s == 2) begin
                n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL avg_no_delta_s2: got %0d expected 0", delta_valid); end
            end
            if (s == 3) begin
                n_checks++; if (delta !== 12'd40 || delta_valid !== 1'b1) begin n_errors++; $display("FAIL avg_delta_s3: got %0d valid %0d expected 40 valid 1", delta, delta_valid); end
            end
            if (s == 4) begin
                n_checks++; if (delta !== 12'd56) begin n_errors++; $display("FAIL avg_delta_s4: got %0d expected 56", delta); end
            end
            if (s == 15) begin
                n_checks++; if (avg_delta !== 12'd48) begin n_errors++; $display("FAIL avg_hold: got %0d expected 48", avg_delta); end
            end
            if (avg_valid) begin
                pulses++;
                n_checks++; if (!(s == 11 || s == 19)) begin n_errors++; $display("FAIL avg_pulse_cycle: got step %0d expected 11 or 19", s); end
                n_checks++; if (avg_delta !== 12'd48) begin n_errors++; $display("FAIL avg_value: got %0d expected 48", avg_delta); end
            end
        end
        n_checks++; if (pulses !== 2) begin n_errors++; $display("FAIL avg_pulse_count: got %0d expected 2", pulses); end
    endtask

    task automatic test_flush;
        int pulses;
        pulses = 0;
        idle(3);
        for (int s = 0; s < 23; s++) begin
            if (s <= 6) step_w(1'b1, alt_word(s));
            else if (s == 7) step(1'b0, 16'h0000, 7'd0);
            else if (s <= 18) step_w(1'b1, 100 + 20 * (s - 8));
            else step(1'b0, 16'h0000, 7'd0);
            if (s == 7) begin
                n_checks++; if (delta !== 12'd40 || delta_valid !== 1'b1) begin n_errors++; $display("FAIL flush_drain_delta: got %0d valid %0d expected 40 valid 1", delta, delta_valid); end
            end
            if (s == 8) begin
                n_checks++; if (tdc_valid !== 1'b0) begin n_errors++; $display("FAIL flush_tdc_gap: got %0d expected 0", tdc_valid); end
                n_checks++; if (tdc_word !== 12'd288) begin n_errors++; $display("FAIL flush_word_hold: got %0d expected 288", tdc_word); end
                n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL flush_delta_gap: got %0d expected 0", delta_valid); end
            end
            if (s == 9) begin
                n_checks++; if (tdc_word !== 12'd100 || tdc_valid !== 1'b1) begin n_errors++; $display("FAIL flush_first_word: got %0d valid %0d expected 100 valid 1", tdc_word, tdc_valid); end
            end
            if (s == 10) begin
                n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL flush_first_no_delta: got %0d expected 0", delta_valid); end
            end
            if (s == 11) begin
                n_checks++; if (delta !== 12'd20 || delta_valid !== 1'b1) begin n_errors++; $display("FAIL flush_new_delta: got %0d valid %0d expected 20 valid 1", delta, delta_valid); end
            end
            if (s == 12) begin
                n_checks++; if (avg_delta !== 12'd48) begin n_errors++; $display("FAIL flush_avg_hold: got %0d expected 48", avg_delta); end
            end
            if (avg_valid) begin
                pulses++;
                n_checks++; if (s !== 19) begin n_errors++; $display("FAIL flush_pulse_cycle: got step %0d expected 19", s); end
                n_checks++; if (avg_delta !== 12'd20) begin n_errors++; $display("FAIL flush_avg_value: got %0d expected 20", avg_delta); end
            end
        end
        n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL flush_pulse_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_async_reset;
        idle(3);
        for (int s = 0; s < 5; s++) step_w(1'b1, alt_word(s));
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (tdc_word !== 12'd0 || tdc_valid !== 1'b0 || bubble_err !== 1'b0) begin n_errors++; $display("FAIL areset_tdc: got word %0d valid %0d bubble %0d expected 0 0 0", tdc_word, tdc_valid, bubble_err); end
        n_checks++; if (delta !== 12'd0 || delta_valid !== 1'b0) begin n_errors++; $display("FAIL areset_delta: got %0d valid %0d expected 0 0", delta, delta_valid); end
        n_checks++; if (avg_delta !== 12'd0 || avg_valid !== 1'b0) begin n_errors++; $display("FAIL areset_avg: got %0d valid %0d expected 0 0", avg_delta, avg_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step_w(1'b1, alt_word(s));
            if (s == 2) begin
                n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL areset_no_delta: got %0d expected 0", delta_valid); end
            end
            if (s == 3) begin
                n_checks++; if (delta !== 12'd40 || delta_valid !== 1'b1) begin n_errors++; $display("FAIL areset_first_delta: got %0d valid %0d expected 40 valid 1", delta, delta_valid); end
            end
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_wrap();
        test_bubble();
        test_averaging();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
